uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_gen.sv | 37 +++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg : shared UART state encoding and default frame/baud parameters -- rev 1.0 ====
package uart_pkg;

  localparam int D_BIT_DEF   = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int DVSR_DEF    = 326;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// ==== baud_gen : free-running 16x oversampling tick divider with sync clear -- rev 1.0 ====
module baud_gen
  import uart_pkg::*;
#(
  parameter int DVSR = DVSR_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic s_tick
);

  localparam int            CW   = cnt_width(DVSR);
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign s_tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ==== uart_tx : UART transmitter FSM, LSB first, configurable data/stop length -- rev 1.0 ====
module uart_tx
  import uart_pkg::*;
#(
  parameter int D_BIT   = D_BIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int DVSR    = DVSR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [D_BIT-1:0] din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int            BW        = cnt_width(D_BIT);
  localparam logic [4:0]    TICK_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [D_BIT-1:0] sreg_q, sreg_d;
  logic [4:0]       tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_tick;
  logic             clr;

  baud_gen #(
    .DVSR (DVSR)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .s_tick (s_tick)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          sreg_d  = din;
          tick_d  = '0;
          bit_d   = '0;
          clr     = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            sreg_d = sreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            state_d = IDLE;
            tick_d  = '0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge as the FSM.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ==== tb_uart_tx : directed self-checking bench for uart_tx (DVSR=2, 1 and 2 stop bits) -- rev 1.0 ====
module tb_uart_tx;

  localparam int D_BIT     = 8;
  localparam int DVSR      = 2;
  localparam int BIT_CYC   = 16 * DVSR;
  localparam int FRAME_CYC = (16 * (1 + D_BIT) + 16) * DVSR;
  localparam int FRAME_B   = (16 * (1 + D_BIT) + 32) * DVSR;
  localparam int DATA_END  = 16 * (1 + D_BIT) * DVSR;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start_a, tx_start_b;
  logic [7:0] din_a, din_b;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx #(.D_BIT(D_BIT), .SB_TICK(16), .DVSR(DVSR)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start_a),
    .din          (din_a),
    .tx           (tx_a),
    .tx_busy      (busy_a),
    .tx_done_tick (done_a)
  );

  uart_tx #(.D_BIT(D_BIT), .SB_TICK(32), .DVSR(DVSR)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start_b),
    .din          (din_b),
    .tx           (tx_b),
    .tx_busy      (busy_b),
    .tx_done_tick (done_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the acceptance edge (1-stop frame, idle after).
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int seg;
    seg = k / BIT_CYC;
    if (seg == 0) return 1'b0;
    if (seg <= D_BIT) return d[seg-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1; tx_start_a = 1'b0; tx_start_b = 1'b0; din_a = 8'h00; din_b = 8'h00;
    repeat (3) begin
      step();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
          tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_outputs: %0d bad cycles, got tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
               bad, tx_a, busy_a, done_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad_tx, bad_busy, bad_done;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (tx_a !== 1'b1 || tx_b !== 1'b1) bad_tx++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) bad_busy++;
      if (done_a !== 1'b0 || done_b !== 1'b0) bad_done++;
    end
    n_tests++;
    if (bad_tx != 0) begin n_fail++; $display("FAIL idle_tx: %0d cycles with tx!=1, expected 0", bad_tx); end
    n_tests++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d cycles with busy!=0, expected 0", bad_busy); end
    n_tests++;
    if (bad_done != 0) begin n_fail++; $display("FAIL idle_done: %0d cycles with done!=0, expected 0", bad_done); end
  endtask

  task automatic test_single_frame();
    int seg_bad[10];
    int busy_bad, done_at, done_cnt;
    logic end_tx, end_busy;
    busy_bad = 0; done_at = -1; done_cnt = 0;
    for (int s = 0; s < 10; s++) seg_bad[s] = 0;
    din_a = 8'hB3; tx_start_a = 1'b1;
    step();
    tx_start_a = 1'b0; din_a = 8'h00;
    for (int k = 0; k <= FRAME_CYC; k++) begin
      if (k < FRAME_CYC) begin
        if (tx_a !== exp_tx(8'hB3, k)) seg_bad[k / BIT_CYC]++;
        if (busy_a !== 1'b1) busy_bad++;
      end
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < FRAME_CYC) step();
    end
    end_tx = tx_a; end_busy = busy_a;
    for (int s = 0; s < 10; s++) begin
      n_tests++;
      if (seg_bad[s] != 0) begin
        n_fail++;
        $display("FAIL single_seg%0d: %0d cycles wrong, expected tx=%b", s, seg_bad[s], exp_tx(8'hB3, s * BIT_CYC));
      end
    end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL single_busy: %0d frame cycles with busy=0, expected 0", busy_bad); end
    n_tests++;
    if (done_at != FRAME_CYC) begin n_fail++; $display("FAIL single_done_at: got %0d, expected %0d", done_at, FRAME_CYC); end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d, expected 1", done_cnt); end
    n_tests++;
    if (end_tx !== 1'b1 || end_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end_idle: got tx=%b busy=%b, expected tx=1 busy=0", end_tx, end_busy);
    end
  endtask

  task automatic test_back_to_back();
    int tx_bad, busy_bad, done_n, d1, d2;
    logic et, eb;
    tx_bad = 0; busy_bad = 0; done_n = 0; d1 = -1; d2 = -1;
    din_a = 8'h00; tx_start_a = 1'b1;
    step();
    for (int k = 0; k <= 2 * FRAME_CYC + 20; k++) begin
      if (k < FRAME_CYC) begin et = exp_tx(8'h00, k); eb = 1'b1; end
      else if (k == FRAME_CYC) begin et = 1'b1; eb = 1'b0; end
      else if (k < 2 * FRAME_CYC + 1) begin et = exp_tx(8'hFF, k - FRAME_CYC - 1); eb = 1'b1; end
      else begin et = 1'b1; eb = 1'b0; end
      if (tx_a !== et) tx_bad++;
      if (busy_a !== eb) busy_bad++;
      if (done_a === 1'b1) begin
        done_n++;
        if (done_n == 1) begin d1 = k; din_a = 8'hFF; end
        else if (done_n == 2) d2 = k;
      end
      if (done_n >= 2) break;
      step();
    end
    tx_start_a = 1'b0;
    n_tests++;
    if (d1 != FRAME_CYC) begin n_fail++; $display("FAIL b2b_done1: got %0d, expected %0d", d1, FRAME_CYC); end
    // Second frame is accepted on the edge right after the first done pulse.
    n_tests++;
    if (d2 != 2 * FRAME_CYC + 1) begin n_fail++; $display("FAIL b2b_done2: got %0d, expected %0d", d2, 2 * FRAME_CYC + 1); end
    n_tests++;
    if (tx_bad != 0) begin n_fail++; $display("FAIL b2b_tx: %0d cycles wrong, expected 0", tx_bad); end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL b2b_busy: %0d cycles wrong, expected 0", busy_bad); end
  endtask

  task automatic test_busy_ignore();
    int tx_bad, busy_bad, done_cnt, done_at;
    tx_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
    step();
    din_a = 8'h55; tx_start_a = 1'b1;
    step();
    tx_start_a = 1'b0;
    for (int k = 0; k <= FRAME_CYC + 80; k++) begin
      if (k == 100) begin tx_start_a = 1'b1; din_a = 8'hAA; end
      else if (k == 101) tx_start_a = 1'b0;
      if (tx_a !== ((k < FRAME_CYC) ? exp_tx(8'h55, k) : 1'b1)) tx_bad++;
      if (busy_a !== ((k < FRAME_CYC) ? 1'b1 : 1'b0)) busy_bad++;
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      step();
    end
    n_tests++;
    if (tx_bad != 0) begin n_fail++; $display("FAIL busy_ignore_tx: %0d cycles wrong, expected 0", tx_bad); end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL busy_ignore_busy: %0d cycles wrong, expected 0", busy_bad); end
    n_tests++;
    if (done_cnt != 1 || done_at != FRAME_CYC) begin
      n_fail++;
      $display("FAIL busy_ignore_done: got count=%0d at=%0d, expected count=1 at=%0d", done_cnt, done_at, FRAME_CYC);
    end
  endtask

  task automatic test_reset_mid_frame();
    int pre_bad, post_bad, done_cnt, tx_bad, done_at;
    logic tx_after, busy_after;
    pre_bad = 0; post_bad = 0; done_cnt = 0; tx_bad = 0; done_at = -1;
    tx_after = 1'bx; busy_after = 1'bx;
    din_a = 8'h0F; tx_start_a = 1'b1;
    step();
    tx_start_a = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      if (k == 150) rst = 1'b1;
      else if (k == 152) rst = 1'b0;
      if (k <= 150) begin
        if (tx_a !== exp_tx(8'h0F, k) || busy_a !== 1'b1) pre_bad++;
      end else begin
        if (k == 151) begin tx_after = tx_a; busy_after = busy_a; end
        if (tx_a !== 1'b1 || busy_a !== 1'b0) post_bad++;
      end
      if (done_a === 1'b1) done_cnt++;
      step();
    end
    n_tests++;
    if (pre_bad != 0) begin n_fail++; $display("FAIL rst_mid_pre: %0d cycles wrong before reset, expected 0", pre_bad); end
    n_tests++;
    if (tx_after !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_edge: got tx=%b busy=%b, expected tx=1 busy=0", tx_after, busy_after);
    end
    n_tests++;
    if (post_bad != 0) begin n_fail++; $display("FAIL rst_mid_post: %0d cycles not idle, expected 0", post_bad); end
    n_tests++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses, expected 0", done_cnt); end
    din_a = 8'h3C; tx_start_a = 1'b1;
    step();
    tx_start_a = 1'b0;
    for (int k = 0; k <= FRAME_CYC; k++) begin
      if (k < FRAME_CYC && tx_a !== exp_tx(8'h3C, k)) tx_bad++;
      if (done_a === 1'b1 && done_at < 0) done_at = k;
      if (k < FRAME_CYC) step();
    end
    n_tests++;
    if (tx_bad != 0) begin n_fail++; $display("FAIL rst_fresh_tx: %0d cycles wrong, expected 0", tx_bad); end
    n_tests++;
    if (done_at != FRAME_CYC) begin n_fail++; $display("FAIL rst_fresh_done: got %0d, expected %0d", done_at, FRAME_CYC); end
  endtask

  task automatic test_stop_length();
    int low_bad, stop_bad, busy_bad, done_at;
    low_bad = 0; stop_bad = 0; busy_bad = 0; done_at = -1;
    step();
    din_b = 8'h00; tx_start_b = 1'b1;
    step();
    tx_start_b = 1'b0;
    for (int k = 0; k <= FRAME_B; k++) begin
      if (k < DATA_END) begin
        if (tx_b !== 1'b0) low_bad++;
      end else if (k < FRAME_B) begin
        if (tx_b !== 1'b1) stop_bad++;
      end
      if (k < FRAME_B && busy_b !== 1'b1) busy_bad++;
      if (done_b === 1'b1 && done_at < 0) done_at = k;
      if (k < FRAME_B) step();
    end
    n_tests++;
    if (low_bad != 0) begin n_fail++; $display("FAIL stop2_low: %0d start/data cycles not low, expected 0", low_bad); end
    n_tests++;
    if (stop_bad != 0) begin n_fail++; $display("FAIL stop2_high: %0d stop cycles not high, expected 0", stop_bad); end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL stop2_busy: %0d cycles wrong, expected 0", busy_bad); end
    n_tests++;
    if (done_at != FRAME_B) begin n_fail++; $display("FAIL stop2_done_at: got %0d, expected %0d", done_at, FRAME_B); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_stop_length();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
